pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register for the RISC-V core. It replaces the fixed-width, always-advancing inter-stage registers (ID/EX, EX/MEM, MEM/WB) with one block that supports valid/ready flow control, stall, flush-to-bubble and an optional two-entry skid buffer. Each instance sits between two pipeline stages and carries a control bundle, a destination register index and NDATA data words. It also counts back-pressure cycles for performance analysis.

---
 rtl/pipe_stage_reg.sv | 176 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: valid/ready flow control, flush-to-bubble,
// saturating back-pressure counter. Define PIPE_SKID_EN for the two-entry skid build.
module pipe_stage_reg #(
   parameter int WIDTH  = 32,
   parameter int NDATA  = 3,
   parameter int CTRL_W = 4,
   parameter int RD_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic [RD_W-1:0]         in_rd,
   input  logic [NDATA*WIDTH-1:0]  in_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [RD_W-1:0]         out_rd,
   output logic [NDATA*WIDTH-1:0]  out_data,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int DW = NDATA * WIDTH;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [RD_W-1:0]   main_rd_q, main_rd_d;
   logic [DW-1:0]     main_data_q, main_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              in_fire, out_fire;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

`ifdef PIPE_SKID_EN
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
   logic [DW-1:0]     skid_data_q, skid_data_d;
   logic              in_ready_q;
`endif

   // State register: control and main-entry contents; rst wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         main_ctrl_q <= '0;
         main_rd_q   <= '0;
         main_data_q <= '0;
         cnt_q       <= '0;
`ifdef PIPE_SKID_EN
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_rd_q   <= main_rd_d;
         main_data_q <= main_data_d;
         cnt_q       <= cnt_d;
`ifdef PIPE_SKID_EN
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= (state_d != S_SKID);
`endif
      end
   end

`ifdef PIPE_SKID_EN
   // Skid payload needs no reset: it is only read while its state says it is valid
   always_ff @(posedge clk) begin
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
   end
`endif

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_rd_d   = main_rd_q;
      main_data_d = main_data_q;
`ifdef PIPE_SKID_EN
      skid_ctrl_d = skid_ctrl_q;
      skid_rd_d   = skid_rd_q;
      skid_data_d = skid_data_q;
`endif
      if (flush) begin
         state_d     = S_EMPTY;
         main_ctrl_d = '0;
`ifdef PIPE_SKID_EN
         skid_ctrl_d = '0;
`endif
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  state_d     = S_FULL;
                  main_ctrl_d = in_ctrl;
                  main_rd_d   = in_rd;
                  main_data_d = in_data;
               end
            end
            S_FULL: begin
               if (in_fire && out_fire) begin
                  main_ctrl_d = in_ctrl;
                  main_rd_d   = in_rd;
                  main_data_d = in_data;
`ifdef PIPE_SKID_EN
               end else if (in_fire) begin
                  // Downstream stalled: the younger instruction parks in the skid entry
                  state_d     = S_SKID;
                  skid_ctrl_d = in_ctrl;
                  skid_rd_d   = in_rd;
                  skid_data_d = in_data;
`endif
               end else if (out_fire) begin
                  state_d     = S_EMPTY;
                  main_ctrl_d = '0;
               end
            end
            S_SKID: begin
`ifdef PIPE_SKID_EN
               if (out_fire) begin
                  state_d     = S_FULL;
                  main_ctrl_d = skid_ctrl_q;
                  main_rd_d   = skid_rd_q;
                  main_data_d = skid_data_q;
                  skid_ctrl_d = '0;
               end
`else
               state_d     = S_EMPTY;
               main_ctrl_d = '0;
`endif
            end
            default: begin
               state_d     = S_EMPTY;
               main_ctrl_d = '0;
            end
         endcase
      end
   end

   // Output logic: out_* come straight from main-entry flops
   always_comb begin
      out_valid = (state_q != S_EMPTY);
      out_ctrl  = main_ctrl_q;
      out_rd    = main_rd_q;
      out_data  = main_data_q;
      stall_cnt = cnt_q;
`ifdef PIPE_SKID_EN
      in_ready  = in_ready_q;
`else
      in_ready  = (state_q == S_EMPTY) | out_ready;
`endif
   end

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Back-pressure counter keeps counting through flush; only rst clears it
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && !out_ready) cnt_d = sat_inc(cnt_q);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic, checked every cycle
// against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

   localparam int WIDTH  = 32;
   localparam int NDATA  = 3;
   localparam int CTRL_W = 4;
   localparam int RD_W   = 5;
   localparam int CNT_W  = 4;
   localparam int DW     = NDATA * WIDTH;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
   localparam int CAP  = 2;
`else
   localparam bit SKID = 1'b0;
   localparam int CAP  = 1;
`endif

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [RD_W-1:0]   in_rd, out_rd;
   logic [DW-1:0]     in_data, out_data;
   logic [CNT_W-1:0]  stall_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .WIDTH(WIDTH), .NDATA(NDATA), .CTRL_W(CTRL_W), .RD_W(RD_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [RD_W-1:0]   rd;
      logic [DW-1:0]     data;
   } item_t;

   item_t q[$];      // instructions held by the stage, oldest first
   int    mcnt;
   bit    rflag;     // no load since reset: payload must still read zero
   int    tests = 0;
   int    fails = 0;

   function automatic bit exp_in_ready();
      if (SKID) return (q.size() < CAP);
      return (q.size() == 0) || out_ready;
   endfunction

   task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [127:0] e;
      cmp("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
      e = (q.size() > 0) ? 128'(q[0].ctrl) : 128'd0;
      cmp("out_ctrl", 128'(out_ctrl), e);
      cmp("in_ready", {127'd0, in_ready}, {127'd0, exp_in_ready()});
      cmp("stall_cnt", 128'(stall_cnt), 128'(mcnt));
      if (q.size() > 0) begin
         cmp("out_rd", 128'(out_rd), 128'(q[0].rd));
         cmp("out_data", 128'(out_data), 128'(q[0].data));
      end else if (rflag) begin
         cmp("out_rd_rst", 128'(out_rd), 128'd0);
         cmp("out_data_rst", 128'(out_data), 128'd0);
      end
   endtask

   task automatic model_edge();
      bit    inf, outf;
      item_t it;
      if (rst) begin
         q.delete();
         mcnt  = 0;
         rflag = 1'b1;
      end else begin
         if (q.size() > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
         if (flush) begin
            q.delete();
         end else begin
            inf  = in_valid && exp_in_ready();
            outf = (q.size() > 0) && out_ready;
            if (outf) void'(q.pop_front());
            if (inf) begin
               it.ctrl = in_ctrl;
               it.rd   = in_rd;
               it.data = in_data;
               q.push_back(it);
            end
         end
         if (q.size() > 0) rflag = 1'b0;
      end
   endtask

   // Called at the falling edge with inputs already applied
   task automatic tick(input bit chk);
      #1;
      if (chk) check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_in(input bit v, input logic [RD_W-1:0] rd);
      in_valid = v;
      in_rd    = rd;
      in_ctrl  = CTRL_W'($urandom);
      in_data  = {$urandom, $urandom, $urandom};
   endtask

   initial begin
      mcnt = 0;
      rflag = 1'b1;
      @(negedge clk);
      // Reset held two cycles with a live input that must be ignored
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 4'hF; in_rd = 5'd9; in_data = '1;
      tick(1'b0);
      tick(1'b1);
      rst = 1'b0;
      set_in(1'b0, 5'd0);
      tick(1'b1);

      // Streaming rd=1..8
      for (int i = 1; i <= 8; i++) begin
         set_in(1'b1, RD_W'(i));
         tick(1'b1);
      end
      set_in(1'b0, 5'd0);
      tick(1'b1);
      tick(1'b1);

      // Back-pressure: out_ready drops once rd=1 is on the output
      out_ready = 1'b1; set_in(1'b1, 5'd1); tick(1'b1);
      out_ready = 1'b0; set_in(1'b1, 5'd2); tick(1'b1);
      set_in(1'b1, 5'd3);
      tick(1'b1); tick(1'b1); tick(1'b1);
      out_ready = 1'b1;
      tick(1'b1); tick(1'b1);
      set_in(1'b0, 5'd0);
      for (int i = 0; i < 4; i++) tick(1'b1);

      // Flush with both entries occupied and an incoming instruction
      out_ready = 1'b1; set_in(1'b1, 5'd4); tick(1'b1);
      out_ready = 1'b0; set_in(1'b1, 5'd5); tick(1'b1);
      set_in(1'b1, 5'd6); flush = 1'b1; tick(1'b1);
      flush = 1'b0; set_in(1'b0, 5'd0); out_ready = 1'b1;
      tick(1'b1); tick(1'b1);

      // Counter saturation, then flush must leave it saturated
      rst = 1'b1; tick(1'b1);
      rst = 1'b0; set_in(1'b1, 5'd7); tick(1'b1);
      set_in(1'b0, 5'd0); out_ready = 1'b0;
      for (int i = 0; i < 20; i++) tick(1'b1);
      cmp("stall_sat", 128'(stall_cnt), 128'(CNT_MAX));
      flush = 1'b1; tick(1'b1);
      flush = 1'b0;
      cmp("stall_after_flush", 128'(stall_cnt), 128'(CNT_MAX));
      tick(1'b1);

      // Release then reset mid-stream
      out_ready = 1'b1; set_in(1'b1, 5'd10); tick(1'b1);
      out_ready = 1'b0; set_in(1'b1, 5'd11); tick(1'b1);
      rst = 1'b1; tick(1'b1);
      rst = 1'b0; set_in(1'b0, 5'd0); out_ready = 1'b1; tick(1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom % 4) != 0, RD_W'($urandom));
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 32) == 0;
         rst       = ($urandom % 97) == 0;
         tick(1'b1);
      end
      rst = 1'b0; flush = 1'b0;
      set_in(1'b0, 5'd0); out_ready = 1'b1;
      tick(1'b1); tick(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
